udm_bus_arb: RTL
================

UDM_BUS_ARB -- requirements
Module: udm_bus_arb

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; RD_DEPTH, 4, maximum outstanding reads (power of 2, >=2).
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk_i, in, 1, single clock, rising edge.
- arst_n_i, in, 1, reset, asynchronous, active-low.
- m0_req_i, m0_we_i, in, 1 each, UDM master request and write-enable.
- m0_addr_bi, in, ADDR_W, UDM master address.
- m0_be_bi, in, DATA_W/8, UDM master byte enables.
- m0_wdata_bi, in, DATA_W, UDM master write data.
- m0_ack_o, m0_resp_o, out, 1 each, UDM master acknowledge and read-response strobe.
- m0_rdata_bo, out, DATA_W, UDM master read data.
- m1_*: identical set for the CPU master.
- s_req_o, s_we_o, out, 1 each, shared-slave request and write-enable.
- s_addr_bo, out, ADDR_W, shared-slave address.
- s_be_bo, out, DATA_W/8, shared-slave byte enables.
- s_wdata_bo, out, DATA_W, shared-slave write data.
- s_ack_i, s_resp_i, in, 1 each, shared-slave acknowledge and read-response strobe.
- s_rdata_bi, in, DATA_W, shared-slave read data.
- err_o, out, 1, sticky flag: unexpected response.

Function
REQ-003 Bus protocol: master holds req/we/addr/be/wdata stable until ack (1-cycle pulse); reads complete with a later 1-cycle resp carrying rdata, in order; writes get no resp.
REQ-004 FSM states SHALL be IDLE and BUSY; a 1-bit owner register holds the granted master.
REQ-005 In IDLE, if any m*_req_i=1 and the tag FIFO is not full, the FSM SHALL register the winner into owner and enter BUSY next cycle; otherwise it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin: if one master requests, it wins; on a tie, the master not granted last wins; after reset, m0 wins the first tie.
REQ-007 In BUSY, s_req/we/addr/be/wdata SHALL combinationally mirror the owner's inputs; in IDLE, s_req_o=0 and the other slave outputs=0.
REQ-008 m<owner>_ack_o SHALL equal s_ack_i while in BUSY; the non-owner ack SHALL be 0; arbitration latency from req to s_req_o is exactly 1 cycle.
REQ-009 On s_ack_i in BUSY: the FSM SHALL return to IDLE and the last-granted pointer SHALL be set to owner; if s_we_o=0, owner SHALL be pushed into the tag FIFO.
REQ-010 If the owner drops req without ack (protocol violation), the FSM SHALL return to IDLE with no push.
REQ-011 Tag FIFO: RD_DEPTH entries of 1 bit, with ptr width log2(RD_DEPTH)+1 for full/empty; a simultaneous push and pop in one cycle SHALL keep the count unchanged.
REQ-012 On s_resp_i with FIFO not empty: pop the head; m<head>_resp_o=1 and m<head>_rdata_bo=s_rdata_bi in the same cycle (combinational); the other master's resp=0.
REQ-013 rdata outputs SHALL be 0 when the corresponding resp is 0.
REQ-014 s_resp_i with FIFO empty SHALL be dropped and SHALL set err_o=1 until reset.
REQ-015 While the FIFO is full, no new grant SHALL be made (REQ-005); a request already in BUSY SHALL proceed.

Reset
REQ-016 On arst_n_i=0, asynchronously: FSM=IDLE, owner=0, last-granted=m1 (so m0 wins the first tie), FIFO empty, err_o=0; all outputs=0.
REQ-017 On reset mid-transaction, all in-flight requests and outstanding responses SHALL be discarded; masters re-request after release.

Structure
REQ-018 The shared package SHALL hold the FSM state enum (IDLE, BUSY) and master-ID constants (MID_UDM=0, MID_CPU=1).
REQ-019 The tag FIFO SHALL be a sub-module udm_bus_arb_tagfifo (push, pop, din, dout, full, empty).

Verification
REQ-020 m0 read at 0x10 only; slave acks the cycle after s_req_o, resp 3 cycles later with 0xDEADBEEF -> s_req_o 1 cycle after m0_req_i; m0_ack_o pulses once; m0_resp_o=1 with 0xDEADBEEF; m1 outputs all 0.
REQ-021 m0 and m1 request continuously (writes) -> grants alternate m0, m1, m0, m1; no cycle has both acks=1.
REQ-022 m0 read, then m1 read, slave resps 0x1111 and 0x2222 in order -> m0 gets 0x1111 and m1 gets 0x2222.
REQ-023 Five m1 reads with resp withheld, RD_DEPTH=4 -> 4 acks, 5th request gets no s_req_o until one resp arrives, then it is granted.
REQ-024 s_resp_i pulse with no outstanding read -> no master resp; err_o=1 sticky; arst_n_i pulse clears it.
REQ-025 arst_n_i low while BUSY with 2 reads outstanding -> s_req_o=0 immediately; after release, the FIFO is empty and a stray resp sets err_o.

Source files
------------

// File: rtl/udm_bus_arb_pkg.sv
// Shared definitions for the UDM/CPU bus arbiter.
//   arb_state_e : arbiter FSM state (ST_IDLE, ST_BUSY)
//   MID_UDM     : master ID of the UDM port (m0)
//   MID_CPU     : master ID of the CPU port (m1)
//   rr_pick     : round-robin winner between the two masters
package udm_bus_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic MID_UDM = 1'b0;
    localparam logic MID_CPU = 1'b1;

    // A lone requester always wins; on a tie the master that was not
    // granted last time goes first.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        logic win;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = MID_CPU;
        end else begin
            win = MID_UDM;
        end
        return win;
    endfunction

endpackage

// File: rtl/udm_bus_arb_tagfifo.sv
// Read-tag FIFO: remembers which master owns each outstanding read so
// that in-order slave responses can be routed back.
// Ports:
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   push_i, din_i   : write one 1-bit master tag
//   pop_i, dout_o   : head tag (valid while !empty_o), removed on pop_i
//   full_o, empty_o : occupancy flags
module udm_bus_arb_tagfifo #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is accepted only when a pop frees a slot in
    // the same cycle, which keeps the count unchanged.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din_i;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/udm_bus_arb.sv
// Two-master round-robin arbiter sharing one slave on the UDM bus.
// m0 is the UDM master, m1 the CPU master.
// Handshake: a master holds req/we/addr/be/wdata until its 1-cycle ack;
// reads later complete, in order, with a 1-cycle resp carrying rdata;
// writes get no resp.
// Ports:
//   clk_i, arst_n_i        : clock, asynchronous active-low reset
//   m0_* / m1_*            : master request side (req, we, addr, be, wdata
//                            in; ack, resp, rdata out)
//   s_*                    : shared slave side (req, we, addr, be, wdata
//                            out; ack, resp, rdata in)
//   err_o                  : sticky, set by a slave resp with no read
//                            outstanding
module udm_bus_arb
    import udm_bus_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                arst_n_i,

    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_bi,
    input  logic [DATA_W/8-1:0] m0_be_bi,
    input  logic [DATA_W-1:0]   m0_wdata_bi,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_bo,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_bi,
    input  logic [DATA_W/8-1:0] m1_be_bi,
    input  logic [DATA_W-1:0]   m1_wdata_bi,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_bo,

    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_bo,
    output logic [DATA_W/8-1:0] s_be_bo,
    output logic [DATA_W-1:0]   s_wdata_bo,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_bi,

    output logic                err_o
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       err_q, err_d;

    logic                busy;
    logic                sel_req;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W/8-1:0] sel_be;
    logic [DATA_W-1:0]   sel_wdata;

    logic tag_push, tag_pop, tag_head, tag_full, tag_empty;

    assign busy = (state_q == ST_BUSY);

    // Owner's request fields
    always_comb begin
        if (owner_q == MID_CPU) begin
            sel_req   = m1_req_i;
            sel_we    = m1_we_i;
            sel_addr  = m1_addr_bi;
            sel_be    = m1_be_bi;
            sel_wdata = m1_wdata_bi;
        end else begin
            sel_req   = m0_req_i;
            sel_we    = m0_we_i;
            sel_addr  = m0_addr_bi;
            sel_be    = m0_be_bi;
            sel_wdata = m0_wdata_bi;
        end
    end

    // Slave side is driven only while a grant is active.
    assign s_req_o    = busy && sel_req;
    assign s_we_o     = busy && sel_we;
    assign s_addr_bo  = busy ? sel_addr  : '0;
    assign s_be_bo    = busy ? sel_be    : '0;
    assign s_wdata_bo = busy ? sel_wdata : '0;

    assign m0_ack_o = busy && (owner_q == MID_UDM) && s_ack_i;
    assign m1_ack_o = busy && (owner_q == MID_CPU) && s_ack_i;

    // Every acknowledged read leaves its owner's tag behind for the resp.
    assign tag_push = busy && s_ack_i && !sel_we;
    assign tag_pop  = s_resp_i && !tag_empty;

    assign m0_resp_o   = tag_pop && (tag_head == MID_UDM);
    assign m1_resp_o   = tag_pop && (tag_head == MID_CPU);
    assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
    assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

    assign err_o = err_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q || (s_resp_i && tag_empty);
        case (state_q)
            ST_IDLE: begin
                // No new grant while every read slot is taken.
                if ((m0_req_i || m1_req_i) && !tag_full) begin
                    owner_d = rr_pick(m0_req_i, m1_req_i, last_q);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_ack_i) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else if (!sel_req) begin
                    // Owner abandoned the request: release the bus, no tag.
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            owner_q <= MID_UDM;
            last_q  <= MID_CPU;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    udm_bus_arb_tagfifo #(
        .DEPTH (RD_DEPTH)
    ) u_tagfifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .push_i   (tag_push),
        .pop_i    (tag_pop),
        .din_i    (owner_q),
        .dout_o   (tag_head),
        .full_o   (tag_full),
        .empty_o  (tag_empty)
    );

endmodule
